keccak_squeeze_stream: RTL and testbench

- Output (squeeze) stage of the Keccak engine.
- Reads the rate portion of the 1600-bit state from the permutation core and streams digest/XOF bytes as a valid/ready stream of OUT_DWIDTH beats.
- Requests extra permutations when the rate block is exhausted; supports all four modes (SHA3_256, SHA3_512, SHAKE128, SHAKE256) and an arbitrary SHAKE output length.

---
 rtl/keccak_squeeze_stream_if.sv | 27 ++
 rtl/keccak_squeeze_stream.sv | 200 ++++++++++++++++++++
 tb/tb_keccak_squeeze_stream.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_squeeze_stream_if.sv
// rtl/keccak_squeeze_stream_if.sv - output byte stream of the Keccak squeeze stage
// The producer drives data/keep/valid/last; the sink drives ready.
interface keccak_squeeze_stream_if #(
    parameter int OUT_DWIDTH = 256
) ();
    logic [OUT_DWIDTH-1:0]   t_data_o;
    logic [OUT_DWIDTH/8-1:0] t_keep_o;
    logic                    t_valid_o;
    logic                    t_last_o;
    logic                    t_ready_i;

    modport master (
        output t_data_o,
        output t_keep_o,
        output t_valid_o,
        output t_last_o,
        input  t_ready_i
    );

    modport slave (
        input  t_data_o,
        input  t_keep_o,
        input  t_valid_o,
        input  t_last_o,
        output t_ready_i
    );
endinterface

// File: rtl/keccak_squeeze_stream.sv
// rtl/keccak_squeeze_stream.sv - Keccak squeeze stage streaming rate bytes as output beats
// Optional macro KECCAK_SQUEEZE_RESUME_EN adds resume_i to continue a finished SHAKE squeeze.
module keccak_squeeze_stream #(
    parameter int OUT_DWIDTH = 256,
    parameter int LANE_SIZE  = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef KECCAK_SQUEEZE_RESUME_EN
    input  logic                   resume_i,
`endif
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic [LEN_WIDTH-1:0]   out_len_i,
    input  logic [25*LANE_SIZE-1:0] state_i,
    input  logic                   state_valid_i,
    output logic                   perm_req_o,
    input  logic                   perm_done_i,
    output logic                   busy_o,
    output logic                   done_o,
    keccak_squeeze_stream_if.master m_axis
);
    localparam int BB = OUT_DWIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, FETCH, EMIT, PERM, WAIT_PERM, DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           offset_q, offset_d;
    logic [7:0]           beat_q, beat_d;
    logic [LEN_WIDTH-1:0] remain_q, remain_d;
    logic [OUT_DWIDTH-1:0] data_q, data_d;
    logic [BB-1:0]        keep_q, keep_d;
    logic                 last_q, last_d;
`ifdef KECCAK_SQUEEZE_RESUME_EN
    logic                 resumable_q, resumable_d;
`endif

    function automatic logic [7:0] rate_of(input logic [1:0] m);
        case (m)
            2'd0:    rate_of = 8'd136;
            2'd1:    rate_of = 8'd72;
            2'd2:    rate_of = 8'd168;
            default: rate_of = 8'd136;
        endcase
    endfunction

    logic [7:0]           rate;
    logic [7:0]           adv_off;
    logic [LEN_WIDTH-1:0] adv_rem;
    logic [7:0]           load_off;
    logic [LEN_WIDTH-1:0] load_rem;
    logic [7:0]           load_size;
    logic [OUT_DWIDTH-1:0] load_data;
    logic [BB-1:0]        load_keep;
    logic                 hs;

    assign rate    = rate_of(mode_q);
    assign adv_off = offset_q + beat_q;
    assign adv_rem = remain_q - LEN_WIDTH'(beat_q);
    assign hs      = (state_q == EMIT) && m_axis.t_ready_i;

    // In EMIT the next beat is taken from the post-handshake position so beats go back-to-back.
    assign load_off = (state_q == EMIT) ? adv_off : offset_q;
    assign load_rem = (state_q == EMIT) ? adv_rem : remain_q;

    always_comb begin
        load_size = 8'(BB);
        if ((rate - load_off) < load_size) load_size = rate - load_off;
        if (load_rem < LEN_WIDTH'(load_size)) load_size = load_rem[7:0];
    end

    always_comb begin
        load_data = '0;
        load_keep = '0;
        for (int j = 0; j < BB; j++) begin
            automatic int idx = 8 * (int'(load_off) + j);
            load_keep[j] = (8'(j) < load_size);
            if (load_keep[j]) load_data[8*j +: 8] = state_i[idx +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            offset_q    <= '0;
            beat_q      <= '0;
            remain_q    <= '0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
`ifdef KECCAK_SQUEEZE_RESUME_EN
            resumable_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            offset_q    <= offset_d;
            beat_q      <= beat_d;
            remain_q    <= remain_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
`ifdef KECCAK_SQUEEZE_RESUME_EN
            resumable_q <= resumable_d;
`endif
        end
    end

    always_comb begin
        logic do_load;
        state_d  = state_q;
        mode_d   = mode_q;
        offset_d = offset_q;
        beat_d   = beat_q;
        remain_d = remain_q;
        data_d   = data_q;
        keep_d   = keep_q;
        last_d   = last_q;
        do_load  = 1'b0;
`ifdef KECCAK_SQUEEZE_RESUME_EN
        resumable_d = resumable_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d   = mode_i;
                    offset_d = '0;
                    case (mode_i)
                        2'd0:    remain_d = LEN_WIDTH'(32);
                        2'd1:    remain_d = LEN_WIDTH'(64);
                        default: remain_d = out_len_i;
                    endcase
                    state_d = (!mode_i[1] || out_len_i != '0) ? FETCH : DONE;
`ifdef KECCAK_SQUEEZE_RESUME_EN
                    resumable_d = 1'b0;
                end else if (resume_i && resumable_q && out_len_i != '0) begin
                    remain_d    = out_len_i;
                    resumable_d = 1'b0;
                    if (offset_q == rate) begin
                        offset_d = '0;
                        state_d  = PERM;
                    end else begin
                        state_d  = FETCH;
                    end
`endif
                end
            end
            FETCH: begin
                if (state_valid_i) begin
                    do_load = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    offset_d = adv_off;
                    remain_d = adv_rem;
                    if (adv_rem == '0) begin
                        state_d = DONE;
                    end else if (adv_off == rate) begin
                        offset_d = '0;
                        state_d  = PERM;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            PERM:      state_d = WAIT_PERM;
            WAIT_PERM: if (perm_done_i) state_d = FETCH;
            DONE: begin
                state_d = IDLE;
`ifdef KECCAK_SQUEEZE_RESUME_EN
                resumable_d = mode_q[1];
`endif
            end
            default:   state_d = IDLE;
        endcase
        if (do_load) begin
            offset_d = load_off;
            remain_d = load_rem;
            beat_d   = load_size;
            data_d   = load_data;
            keep_d   = load_keep;
            last_d   = (load_rem == LEN_WIDTH'(load_size));
        end
    end

    assign m_axis.t_valid_o = (state_q == EMIT);
    assign m_axis.t_data_o  = (state_q == EMIT) ? data_q : '0;
    assign m_axis.t_keep_o  = (state_q == EMIT) ? keep_q : '0;
    assign m_axis.t_last_o  = (state_q == EMIT) && last_q;
    assign perm_req_o       = (state_q == PERM);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);
endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// tb/tb_keccak_squeeze_stream.sv - directed self-checking bench for keccak_squeeze_stream
module tb_keccak_squeeze_stream;
    localparam int OW = 256;
    localparam int LS = 64;
    localparam int LW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_i, state_valid_i, perm_done_i;
    logic [1:0]    mode_i;
    logic [LW-1:0] out_len_i;
    logic [1599:0] state_i;
    logic          perm_req_o, busy_o, done_o;

    keccak_squeeze_stream_if #(.OUT_DWIDTH(OW)) axis ();

    keccak_squeeze_stream #(.OUT_DWIDTH(OW), .LANE_SIZE(LS), .LEN_WIDTH(LW)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef KECCAK_SQUEEZE_RESUME_EN
        .resume_i      (1'b0),
`endif
        .start_i       (start_i),
        .mode_i        (mode_i),
        .out_len_i     (out_len_i),
        .state_i       (state_i),
        .state_valid_i (state_valid_i),
        .perm_req_o    (perm_req_o),
        .perm_done_i   (perm_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .m_axis        (axis.master)
    );

    int total = 0;
    int bad   = 0;
    int perm_cnt = 0, done_cnt = 0, vcyc = 0, hs_cnt = 0;

    always @(posedge clk) begin
        if (perm_req_o) perm_cnt <= perm_cnt + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (axis.t_valid_o) vcyc <= vcyc + 1;
        if (axis.t_valid_o && axis.t_ready_i) hs_cnt <= hs_cnt + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern 0: byte k = k; pattern 1 (after a permutation): byte k = k ^ 0xA5.
    task automatic set_pattern(input bit b);
        for (int k = 0; k < 200; k++) state_i[8*k +: 8] = b ? (8'(k) ^ 8'hA5) : 8'(k);
    endtask

    function automatic logic [255:0] exp_data(input int off, input int size, input bit b);
        logic [255:0] d = '0;
        for (int j = 0; j < size; j++) d[8*j +: 8] = b ? (8'(off + j) ^ 8'hA5) : 8'(off + j);
        return d;
    endfunction

    function automatic logic [31:0] exp_keep(input int size);
        logic [63:0] t = (64'd1 << size) - 64'd1;
        return t[31:0];
    endfunction

    task automatic do_start(input logic [1:0] m, input logic [LW-1:0] len);
        start_i   = 1'b1;
        mode_i    = m;
        out_len_i = len;
        step();
        start_i   = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input int off, input int size, input bit last, input bit pat);
        int n = 0;
        while (axis.t_valid_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 256'(axis.t_valid_o), 256'(1));
        chk({tag, "_data"}, axis.t_data_o, exp_data(off, size, pat));
        chk({tag, "_keep"}, 256'(axis.t_keep_o), 256'(exp_keep(size)));
        chk({tag, "_last"}, 256'(axis.t_last_o), 256'(last));
        step();
    endtask

    initial begin
        int p0, d0, h0, v0, got;
        bit rdy;
        int offs[3]  = '{32, 64, 96};
        int sizes[3] = '{32, 32, 4};
        bit lasts[3] = '{1'b0, 1'b0, 1'b1};

        rst = 1'b1; start_i = 1'b0; mode_i = 2'd0; out_len_i = '0;
        state_valid_i = 1'b1; perm_done_i = 1'b0; axis.t_ready_i = 1'b1;
        state_i = '0;
        set_pattern(1'b0);
        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid", 256'(axis.t_valid_o), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_done", 256'(done_o), 256'(0));
        chk("rst_perm", 256'(perm_req_o), 256'(0));
        chk("rst_data", axis.t_data_o, 256'(0));
        chk("rst_keep", 256'(axis.t_keep_o), 256'(0));

        // SHA3_256: single 32-byte beat, valid two cycles after start
        p0 = perm_cnt; d0 = done_cnt;
        do_start(2'd0, 16'd7);
        chk("s256_lat1_valid", 256'(axis.t_valid_o), 256'(0));
        chk("s256_busy", 256'(busy_o), 256'(1));
        step();
        chk("s256_lat2_valid", 256'(axis.t_valid_o), 256'(1));
        expect_beat("s256_b0", 0, 32, 1'b1, 1'b0);
        chk("s256_done", 256'(done_o), 256'(1));
        step();
        chk("s256_done_off", 256'(done_o), 256'(0));
        chk("s256_idle", 256'(busy_o), 256'(0));
        chk("s256_perm_cnt", 256'(perm_cnt - p0), 256'(0));
        chk("s256_done_cnt", 256'(done_cnt - d0), 256'(1));

        // SHA3_512: two beats
        p0 = perm_cnt;
        do_start(2'd1, 16'd0);
        expect_beat("s512_b0", 0, 32, 1'b0, 1'b0);
        expect_beat("s512_b1", 32, 32, 1'b1, 1'b0);
        chk("s512_done", 256'(done_o), 256'(1));
        chk("s512_perm_cnt", 256'(perm_cnt - p0), 256'(0));

        // SHAKE128 200 bytes: crosses the 168-byte rate once
        step();
        p0 = perm_cnt; h0 = hs_cnt;
        do_start(2'd2, 16'd200);
        for (int i = 0; i < 5; i++) expect_beat("k128_full", 32 * i, 32, 1'b0, 1'b0);
        expect_beat("k128_tail", 160, 8, 1'b0, 1'b0);
        chk("k128_perm_req", 256'(perm_req_o), 256'(1));
        step();
        chk("k128_perm_one_cycle", 256'(perm_req_o), 256'(0));
        v0 = vcyc;
        set_pattern(1'b1);
        repeat (4) step();
        chk("k128_no_out_wait", 256'(vcyc - v0), 256'(0));
        perm_done_i = 1'b1;
        step();
        perm_done_i = 1'b0;
        expect_beat("k128_after_perm", 0, 32, 1'b1, 1'b1);
        chk("k128_done", 256'(done_o), 256'(1));
        chk("k128_perm_cnt", 256'(perm_cnt - p0), 256'(1));
        chk("k128_beats", 256'(hs_cnt - h0), 256'(7));

        // SHAKE256 100 bytes with backpressure
        step();
        set_pattern(1'b0);
        do_start(2'd3, 16'd100);
        expect_beat("bp_b0", 0, 32, 1'b0, 1'b0);
        axis.t_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 256'(axis.t_valid_o), 256'(1));
            chk("bp_hold_data", axis.t_data_o, exp_data(32, 32, 1'b0));
            chk("bp_hold_keep", 256'(axis.t_keep_o), 256'(32'hFFFF_FFFF));
            start_i = (i == 2);
            mode_i  = 2'd0;
            step();
        end
        start_i = 1'b0;
        got = 0;
        rdy = 1'b0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            rdy = !rdy;
            axis.t_ready_i = rdy;
            if (axis.t_valid_o && rdy) begin
                chk("bp_tog_data", axis.t_data_o, exp_data(offs[got], sizes[got], 1'b0));
                chk("bp_tog_keep", 256'(axis.t_keep_o), 256'(exp_keep(sizes[got])));
                chk("bp_tog_last", 256'(axis.t_last_o), 256'(lasts[got]));
                got++;
            end
            step();
        end
        axis.t_ready_i = 1'b1;
        chk("bp_beats", 256'(got), 256'(3));
        chk("bp_done", 256'(done_o), 256'(1));

        // SHAKE256 zero length and 5 bytes
        step();
        v0 = vcyc; d0 = done_cnt;
        do_start(2'd3, 16'd0);
        chk("z_done", 256'(done_o), 256'(1));
        step();
        chk("z_done_off", 256'(done_o), 256'(0));
        chk("z_no_valid", 256'(vcyc - v0), 256'(0));
        chk("z_done_cnt", 256'(done_cnt - d0), 256'(1));
        do_start(2'd3, 16'd5);
        expect_beat("l5", 0, 5, 1'b1, 1'b0);
        chk("l5_done", 256'(done_o), 256'(1));

        // Reset while waiting for a permutation
        step();
        do_start(2'd2, 16'd200);
        for (int i = 0; i < 5; i++) expect_beat("rw_full", 32 * i, 32, 1'b0, 1'b0);
        expect_beat("rw_tail", 160, 8, 1'b0, 1'b0);
        chk("rw_perm_req", 256'(perm_req_o), 256'(1));
        step();
        chk("rw_wait_busy", 256'(busy_o), 256'(1));
        rst = 1'b1;
        step();
        chk("rw_perm", 256'(perm_req_o), 256'(0));
        chk("rw_valid", 256'(axis.t_valid_o), 256'(0));
        chk("rw_busy", 256'(busy_o), 256'(0));
        chk("rw_done", 256'(done_o), 256'(0));
        chk("rw_data", axis.t_data_o, 256'(0));
        chk("rw_keep", 256'(axis.t_keep_o), 256'(0));
        chk("rw_last", 256'(axis.t_last_o), 256'(0));
        rst = 1'b0;
        step();
        do_start(2'd0, 16'd0);
        expect_beat("rw_s256", 0, 32, 1'b1, 1'b0);
        chk("rw_s256_done", 256'(done_o), 256'(1));

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
